// File: rtl/bsg_div_if.sv
// Handshake and operand/result bundle for the iterative divider.
// The divider connects through the slave modport; the producer/consumer uses master.
interface bsg_div_if #(
    parameter int width_p = 32
);
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] dividend_i;
    logic [width_p-1:0] divisor_i;
    logic               signed_i;
    logic [width_p-1:0] quotient_o;
    logic [width_p-1:0] remainder_o;
    logic               v_o;
    logic               yumi_i;

    modport master (
        output v_i, dividend_i, divisor_i, signed_i, yumi_i,
        input  ready_o, quotient_o, remainder_o, v_o
    );

    modport slave (
        input  v_i, dividend_i, divisor_i, signed_i, yumi_i,
        output ready_o, quotient_o, remainder_o, v_o
    );
endinterface

// File: rtl/bsg_div_iterative_radix2.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, signed or unsigned.
// Divide-by-zero and signed overflow produce RISC-V M results.
module bsg_div_iterative_radix2 #(
    parameter int width_p = 32
) (
    input  logic   clk_i,
    input  logic   reset_i,
    bsg_div_if.slave div
);
    localparam int                  cnt_w_lp    = $clog2(width_p);
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(width_p - 1);

    typedef enum logic [2:0] {eIDLE, eABS, eDIV, eFIX, eDONE} state_e;

    state_e state_r, state_n;

    logic [width_p-1:0]  dividend_r;
    logic [width_p-1:0]  divisor_r;
    logic [width_p-1:0]  orig_r;
    logic [width_p-1:0]  quotient_r;
    logic [width_p-1:0]  remainder_r;
    logic [width_p:0]    rem_r;
    logic [width_p:0]    rem_shifted;
    logic [width_p:0]    trial;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                zero_r;
    logic                dneg_r;
    logic                sneg_r;
    logic                accept;
    logic                trial_ok;
    logic                cnt_done;

    assign accept      = div.v_i & (state_r == eIDLE);
    assign rem_shifted = {rem_r[width_p-1:0], dividend_r[width_p-1]};
    assign trial       = rem_shifted - {1'b0, divisor_r};
    // For a nonzero divisor rem_r stays below it, so its top bit is clear and only trial's sign decides.
    assign trial_ok    = ~trial[width_p] & ~rem_r[width_p];
    assign cnt_done    = (cnt_r == cnt_last_lp);

    assign div.ready_o     = (state_r == eIDLE);
    assign div.v_o         = (state_r == eDONE);
    assign div.quotient_o  = quotient_r;
    assign div.remainder_o = remainder_r;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= eIDLE;
        else         state_r <= state_n;
    end

    always_comb begin
        // NOTE: default first so no path through this block leaves state_n unassigned (no latch).
        state_n = state_r;
        unique case (state_r)
            eIDLE:   if (div.v_i)    state_n = eABS;
            eABS:                    state_n = eDIV;
            eDIV:    if (cnt_done)   state_n = eFIX;
            eFIX:                    state_n = eDONE;
            eDONE:   if (div.yumi_i) state_n = eIDLE;
            default:                 state_n = eIDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so results read exactly 0 after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dividend_r  <= '0;
            divisor_r   <= '0;
            orig_r      <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            rem_r       <= '0;
            cnt_r       <= '0;
            zero_r      <= 1'b0;
            dneg_r      <= 1'b0;
            sneg_r      <= 1'b0;
        end else begin
            case (state_r)
                eIDLE: begin
                    if (accept) begin
                        dividend_r <= div.dividend_i;
                        divisor_r  <= div.divisor_i;
                        orig_r     <= div.dividend_i;
                        zero_r     <= (div.divisor_i == '0);
                        dneg_r     <= div.signed_i & div.dividend_i[width_p-1];
                        sneg_r     <= div.signed_i & div.divisor_i[width_p-1];
                    end
                end
                eABS: begin
                    dividend_r <= dneg_r ? -dividend_r : dividend_r;
                    divisor_r  <= sneg_r ? -divisor_r  : divisor_r;
                    rem_r      <= '0;
                    cnt_r      <= '0;
                end
                eDIV: begin
                    rem_r      <= trial_ok ? trial : rem_shifted;
                    dividend_r <= {dividend_r[width_p-2:0], trial_ok};
                    cnt_r      <= cnt_r + 1'b1;
                end
                eFIX: begin
                    // The -2^(w-1) / -1 case needs no special handling: the magnitude wraps back to itself.
                    if (zero_r) begin
                        quotient_r  <= '1;
                        remainder_r <= orig_r;
                    end else begin
                        quotient_r  <= (dneg_r ^ sneg_r) ? -dividend_r : dividend_r;
                        remainder_r <= dneg_r ? -rem_r[width_p-1:0] : rem_r[width_p-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_div_iterative_radix2.sv
// Self-checking bench: directed cases at width 32, then randomized back-to-back traffic
// at widths 8, 16 and 32 scored against a plain-arithmetic reference.
module tb_bsg_div_iterative_radix2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        v_in    [3];
    logic        yumi_in [3];
    logic        sgn_in  [3];
    logic [31:0] opa     [3];
    logic [31:0] opb     [3];

    int vec_cnt = 0;
    int err_cnt = 0;

    bsg_div_if #(.width_p(8))  if8 ();
    bsg_div_if #(.width_p(16)) if16 ();
    bsg_div_if #(.width_p(32)) if32 ();

    assign if8.v_i         = v_in[0];
    assign if8.yumi_i      = yumi_in[0];
    assign if8.signed_i    = sgn_in[0];
    assign if8.dividend_i  = opa[0][7:0];
    assign if8.divisor_i   = opb[0][7:0];
    assign if16.v_i        = v_in[1];
    assign if16.yumi_i     = yumi_in[1];
    assign if16.signed_i   = sgn_in[1];
    assign if16.dividend_i = opa[1][15:0];
    assign if16.divisor_i  = opb[1][15:0];
    assign if32.v_i        = v_in[2];
    assign if32.yumi_i     = yumi_in[2];
    assign if32.signed_i   = sgn_in[2];
    assign if32.dividend_i = opa[2];
    assign if32.divisor_i  = opb[2];

    bsg_div_iterative_radix2 #(.width_p(8))  dut8  (.clk_i(clk), .reset_i(reset), .div(if8));
    bsg_div_iterative_radix2 #(.width_p(16)) dut16 (.clk_i(clk), .reset_i(reset), .div(if16));
    bsg_div_iterative_radix2 #(.width_p(32)) dut32 (.clk_i(clk), .reset_i(reset), .div(if32));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned division with truncation toward zero, RISC-V divide-by-zero rule.
    function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic sgn, output logic [31:0] q, output logic [31:0] r);
        longint mask, sa, sb, qq, rr;
        mask = (longint'(1) << w) - 1;
        sa   = longint'(a) & mask;
        sb   = longint'(b) & mask;
        if (sb == 0) begin
            q = 32'(mask);
            r = 32'(sa);
        end else begin
            if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
            if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
            qq = sa / sb;
            rr = sa % sb;
            q  = 32'(qq & mask);
            r  = 32'(rr & mask);
        end
    endfunction

    // Directed width-32 transaction; starts and ends 1 time unit after a rising edge.
    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                         input bit hold, input bit pulse);
        int lat;
        bit got;
        check({tag, "_ready"}, if32.ready_o, 1'b1);
        opa[2] = a; opb[2] = b; sgn_in[2] = sgn; v_in[2] = 1'b1;
        @(posedge clk); #1;
        v_in[2] = 1'b0;
        opa[2] = $urandom; opb[2] = $urandom;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            yumi_in[2] = pulse && (lat == 5);
            if (if32.v_o) got = 1'b1;
            else          check({tag, "_busy"}, if32.ready_o, 1'b0);
        end
        yumi_in[2] = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'd34);
        check({tag, "_q"}, if32.quotient_o, eq);
        check({tag, "_r"}, if32.remainder_o, er);
        if (hold) begin
            repeat (5) begin
                @(posedge clk); #1;
                check({tag, "_hold_v"}, if32.v_o, 1'b1);
                check({tag, "_hold_q"}, if32.quotient_o, eq);
                check({tag, "_hold_r"}, if32.remainder_o, er);
            end
        end
        yumi_in[2] = 1'b1;
        @(posedge clk); #1;
        yumi_in[2] = 1'b0;
        check({tag, "_idle_ready"}, if32.ready_o, 1'b1);
        check({tag, "_idle_v"}, if32.v_o, 1'b0);
    endtask

    int          wid     [3] = '{8, 16, 32};
    bit          pending [3];
    bit          seen    [3];
    int          acc_cyc [3];
    logic [31:0] exp_q   [3];
    logic [31:0] exp_r   [3];

    // Called at the falling edge: decides what the coming rising edge will accept or retire.
    task automatic sample(input int k, input logic rdy, input logic vo,
                          input logic [31:0] q, input logic [31:0] r, input int cyc);
        check($sformatf("w%0d_excl", wid[k]), 64'(rdy & vo), 64'd0);
        if (vo && !seen[k]) begin
            seen[k] = 1'b1;
            check($sformatf("w%0d_expected", wid[k]), 64'(pending[k]), 64'd1);
            check($sformatf("w%0d_lat", wid[k]), 64'(cyc - 1 - acc_cyc[k]), 64'(wid[k] + 2));
        end
        if (vo && yumi_in[k]) begin
            check($sformatf("w%0d_q a=%0h b=%0h", wid[k], opa[k], opb[k]), q, exp_q[k]);
            check($sformatf("w%0d_r", wid[k]), r, exp_r[k]);
            pending[k] = 1'b0;
            seen[k]    = 1'b0;
        end
        if (v_in[k] && rdy) begin
            ref_div(wid[k], opa[k], opb[k], sgn_in[k], exp_q[k], exp_r[k]);
            pending[k] = 1'b1;
            acc_cyc[k] = cyc;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            v_in[k] = 1'b0; yumi_in[k] = 1'b0; sgn_in[k] = 1'b0;
            opa[k] = '0; opb[k] = '0;
            pending[k] = 1'b0; seen[k] = 1'b0; acc_cyc[k] = 0;
            exp_q[k] = '0; exp_r[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", if32.ready_o, 1'b1);
        check("rst_v", if32.v_o, 1'b0);
        check("rst_q", if32.quotient_o, 32'h0);
        check("rst_r", if32.remainder_o, 32'h0);
        check("rst_ready8", if8.ready_o, 1'b1);

        run32("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,       32'd2,        1'b1, 1'b1);
        run32("sn100_7",  32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0);
        run32("s100_n7",  32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0);
        run32("umax_max", 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,        32'd0,        1'b0, 1'b0);
        run32("s_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,        1'b0, 1'b0);
        run32("sdiv0",    32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 1'b0);

        // Abort in eDIV cycle 10: stale nonzero outputs must clear without a clock edge.
        opa[2] = 32'h1234; opb[2] = 32'd7; sgn_in[2] = 1'b0; v_in[2] = 1'b1;
        @(posedge clk); #1;
        v_in[2] = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("abort_busy", if32.ready_o, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("abort_ready", if32.ready_o, 1'b1);
        check("abort_v", if32.v_o, 1'b0);
        check("abort_q", if32.quotient_o, 32'h0);
        check("abort_r", if32.remainder_o, 32'h0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        run32("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);

        for (int cyc = 0; cyc < 3060; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                opa[k] = $urandom;
                opb[k] = $urandom;
                case ($urandom_range(0, 7))
                    0: opb[k] = '0;
                    1: opb[k] = '1;
                    2: begin opa[k] = 32'h1 << (wid[k] - 1); opb[k] = '1; end
                    3: opb[k] = $urandom_range(1, 5);
                    default: ;
                endcase
                sgn_in[k]  = 1'($urandom_range(0, 1));
                v_in[k]    = (cyc < 3000);
                yumi_in[k] = (cyc >= 3000) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            sample(0, if8.ready_o,  if8.v_o,  32'(if8.quotient_o),  32'(if8.remainder_o),  cyc);
            sample(1, if16.ready_o, if16.v_o, 32'(if16.quotient_o), 32'(if16.remainder_o), cyc);
            sample(2, if32.ready_o, if32.v_o, if32.quotient_o,      if32.remainder_o,      cyc);
        end
        for (int k = 0; k < 3; k++)
            check($sformatf("w%0d_drained", wid[k]), 64'(pending[k]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
